// File: rtl/axi_line_arbiter.sv
// Purpose: shares one single-beat cache-line AXI master port between two line requesters (0 = I-cache refill, 1 = D-cache).
// Latency: grant is combinational in IDLE; with a zero-wait slave the response pulse comes 3 cycles after accept.
// Backpressure: one transaction outstanding; requests wait (valid held) until IDLE; AXI valids hold until ready.
//
// Ports:
//   clk, rst_n                       clock (rising edge), asynchronous active-low reset
//   uN_req_valid/write/addr/wdata    request from requester N, held until uN_req_ready
//   uN_req_ready                     one-cycle accept pulse, only to the granted requester
//   uN_resp_valid/rdata              one-cycle completion pulse; rdata meaningful on reads
//   busy, grant_id                   transaction in flight / requester that owns it
//   axi_*                            AW/W/B and AR/R channels of the shared master port
module axi_line_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 512,
    parameter int FIXED_PRIO = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    u0_req_valid,
    input  logic                    u0_req_write,
    input  logic [ADDR_WIDTH-1:0]   u0_req_addr,
    input  logic [LINE_BITS-1:0]    u0_req_wdata,
    output logic                    u0_req_ready,
    output logic                    u0_resp_valid,
    output logic [LINE_BITS-1:0]    u0_resp_rdata,

    input  logic                    u1_req_valid,
    input  logic                    u1_req_write,
    input  logic [ADDR_WIDTH-1:0]   u1_req_addr,
    input  logic [LINE_BITS-1:0]    u1_req_wdata,
    output logic                    u1_req_ready,
    output logic                    u1_resp_valid,
    output logic [LINE_BITS-1:0]    u1_resp_rdata,

    output logic                    busy,
    output logic                    grant_id,

    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    output logic [LINE_BITS-1:0]    axi_wdata,
    output logic [LINE_BITS/8-1:0]  axi_wstrb,
    output logic                    axi_wlast,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,

    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,
    input  logic [LINE_BITS-1:0]    axi_rdata
);

    localparam int STRB_W = LINE_BITS / 8;
    localparam int OFS    = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-OFS){1'b1}}, {OFS{1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AWW  = 3'd3,
        B    = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LINE_BITS-1:0]   wdata_q;
    logic                   grant_q;
    logic                   last_grant;
    logic                   aw_done, w_done;

    // Arbitration (only meaningful in IDLE)
    logic                   gnt_any, gnt_id;
    logic                   sel_write;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LINE_BITS-1:0]   sel_wdata;
    logic                   resp_evt;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (state == IDLE) begin
            if (u0_req_valid && u1_req_valid) begin
                gnt_any = 1'b1;
                // Round-robin hands a tie to whoever did not win last time.
                gnt_id  = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant;
            end else if (u0_req_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (u1_req_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign sel_write = gnt_id ? u1_req_write : u0_req_write;
    assign sel_addr  = gnt_id ? u1_req_addr  : u0_req_addr;
    assign sel_wdata = gnt_id ? u1_req_wdata : u0_req_wdata;

    assign u0_req_ready = gnt_any & ~gnt_id;
    assign u1_req_ready = gnt_any &  gnt_id;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gnt_any)     state_nxt = sel_write ? AWW : AR;
            AR:   if (axi_arready) state_nxt = R;
            R:    if (axi_rvalid)  state_nxt = IDLE;
            // A handshake completing this cycle counts the same as one already done.
            AWW:  if ((aw_done || axi_awready) && (w_done || axi_wready)) state_nxt = B;
            B:    if (axi_bvalid)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    assign resp_evt = ((state == R) && axi_rvalid) || ((state == B) && axi_bvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            grant_q       <= 1'b0;
            last_grant    <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            u0_resp_valid <= 1'b0;
            u1_resp_valid <= 1'b0;
            u0_resp_rdata <= '0;
            u1_resp_rdata <= '0;
        end else begin
            state         <= state_nxt;
            u0_resp_valid <= resp_evt & ~grant_q;
            u1_resp_valid <= resp_evt &  grant_q;

            if (gnt_any) begin
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
                grant_q    <= gnt_id;
                last_grant <= gnt_id;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end

            if (axi_awvalid && axi_awready) aw_done <= 1'b1;
            if (axi_wvalid && axi_wready)   w_done  <= 1'b1;

            if ((state == R) && axi_rvalid) begin
                if (grant_q) u1_resp_rdata <= axi_rdata;
                else         u0_resp_rdata <= axi_rdata;
            end
        end
    end

    // Valids decode straight from state so an async reset drops them at once.
    assign busy        = (state != IDLE);
    assign grant_id    = grant_q;

    assign axi_arvalid = (state == AR);
    assign axi_araddr  = addr_q & ADDR_MASK;
    assign axi_rready  = (state == R);

    assign axi_awvalid = (state == AWW) && !aw_done;
    assign axi_awaddr  = addr_q & ADDR_MASK;
    assign axi_wvalid  = (state == AWW) && !w_done;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = (state == AWW) ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
    assign axi_wlast   = (state == AWW);
    assign axi_bready  = (state == B);

endmodule
